// File: rtl/btn_cmd_gen.sv
// Push-button front end: three raw buttons are synchronized, debounced and
// edge-detected, then priority-encoded into single-cycle start/stop/reset commands.
module btn_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_raw,
  input  logic       btn_stop_raw,
  input  logic       btn_reset_raw,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic [2:0] btn_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] deb;
  logic [2:0] press;

  assign raw = {btn_reset_raw, btn_stop_raw, btn_start_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic             s1_reg;
      logic             s2_reg;
      logic             deb_reg;
      logic             deb_d_reg;
      logic [CNT_W-1:0] cnt_reg;

      // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples;
      // a single agreeing sample restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_reg    <= 1'b0;
          s2_reg    <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          s1_reg    <= raw[gi];
          s2_reg    <= s1_reg;
          deb_d_reg <= deb_reg;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_MAX) begin
            deb_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign deb[gi]   = deb_reg;
      assign press[gi] = deb_reg & ~deb_d_reg;
    end
  endgenerate

  // Lower-priority presses in the same cycle are dropped, never deferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reset <= 1'b0;
      stop  <= 1'b0;
      start <= 1'b0;
    end else begin
      reset <= press[2];
      stop  <= press[1] & ~press[2];
      start <= press[0] & ~press[1] & ~press[2];
    end
  end

  assign btn_level = deb;

endmodule

// File: tb/tb_btn_cmd_gen.sv
// Directed bench for btn_cmd_gen: expected command pulses are queued with the
// edge they must appear on; a negedge monitor compares every cycle.
module tb_btn_cmd_gen;

  localparam int DEB = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_start_raw;
  logic       btn_stop_raw;
  logic       btn_reset_raw;
  logic       start;
  logic       stop;
  logic       reset;
  logic [2:0] btn_level;

  typedef struct {
    int         edge_n;
    logic [2:0] cmd;
  } exp_t;

  exp_t exp_q[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;

  btn_cmd_gen #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_start_raw (btn_start_raw),
    .btn_stop_raw  (btn_stop_raw),
    .btn_reset_raw (btn_reset_raw),
    .start         (start),
    .stop          (stop),
    .reset         (reset),
    .btn_level     (btn_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_cnt, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input driven now is captured at the next edge k; its pulse is seen after edge k+2+DEB.
  task automatic push(input logic [2:0] cmd);
    exp_t e;
    e.edge_n = edge_cnt + 1 + DEB + 2;
    e.cmd    = cmd;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the command outputs must equal the queued pulse or zero.
  always @(negedge clk) begin
    logic [2:0] expv;
    expv = 3'b000;
    if (exp_q.size() > 0 && exp_q[0].edge_n == edge_cnt) begin
      expv = exp_q[0].cmd;
      void'(exp_q.pop_front());
      $display("txn edge=%0d expect {reset,stop,start}=%b got=%b", edge_cnt, expv, {reset, stop, start});
    end
    chk("cmd", {reset, stop, start}, expv);
  end

  initial begin
    int bounce [10];
    bounce = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    rst_n         = 1'b0;
    btn_start_raw = 1'b0;
    btn_stop_raw  = 1'b0;
    btn_reset_raw = 1'b0;

    // Reset state
    step(2);
    chk("rst_level", btn_level, 3'b000);
    rst_n = 1'b1;

    // Clean press captured at edge 10
    step(7);
    btn_start_raw = 1'b1;
    push(3'b001);
    step(5);
    chk("clean_level_pre", btn_level, 3'b000);
    step(1);
    chk("clean_level_up", btn_level, 3'b001);
    step(14);
    btn_start_raw = 1'b0;
    step(5);
    chk("clean_level_hold", btn_level, 3'b001);
    step(1);
    chk("clean_level_down", btn_level, 3'b000);
    step(4);

    // Bounce on stop: only the final stable run counts
    for (int i = 0; i < 10; i++) begin
      btn_stop_raw = bounce[i][0];
      if (i == 5) push(3'b010);
      step(1);
    end
    chk("bounce_level_pre", btn_level, 3'b000);
    step(1);
    chk("bounce_level_up", btn_level, 3'b010);
    step(5);
    btn_stop_raw = 1'b0;
    step(2 * DEB + 4);
    chk("bounce_level_down", btn_level, 3'b000);

    // Glitch of 3 cycles on reset never debounces
    btn_reset_raw = 1'b1;
    step(3);
    btn_reset_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch_level", btn_level, 3'b000);
    end

    // Simultaneous press: reset wins
    btn_start_raw = 1'b1;
    btn_stop_raw  = 1'b1;
    btn_reset_raw = 1'b1;
    push(3'b100);
    step(5);
    chk("simul_level_pre", btn_level, 3'b000);
    step(1);
    chk("simul_level_up", btn_level, 3'b111);
    step(4);
    btn_start_raw = 1'b0;
    btn_stop_raw  = 1'b0;
    btn_reset_raw = 1'b0;
    step(2 * DEB + 4);
    chk("simul_level_down", btn_level, 3'b000);

    // Staggered press: start then stop one cycle later
    btn_start_raw = 1'b1;
    push(3'b001);
    step(1);
    btn_stop_raw = 1'b1;
    push(3'b010);
    step(8);
    chk("stagger_level", btn_level, 3'b011);
    btn_start_raw = 1'b0;
    btn_stop_raw  = 1'b0;
    step(2 * DEB + 4);
    chk("stagger_level_down", btn_level, 3'b000);

    // Async reset while start is held with a partial count
    btn_start_raw = 1'b1;
    step(4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cmd", {reset, stop, start}, 3'b000);
    chk("async_rst_level", btn_level, 3'b000);
    step(2);
    rst_n = 1'b1;
    push(3'b001);
    step(5);
    chk("after_rst_level_pre", btn_level, 3'b000);
    step(1);
    chk("after_rst_level_up", btn_level, 3'b001);
    step(6);
    btn_start_raw = 1'b0;
    step(2 * DEB + 4);
    chk("after_rst_level_down", btn_level, 3'b000);

    checks++;
    assert (exp_q.size() === 0)
    else begin
      errors++;
      $error("FAIL pending_pulses observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
